// File: rtl/fight_pkg.sv
// Shared definitions for the fighter-core vitality bookkeeping: player FSM
// state codes, the round FSM encoding and the stun-entry helper.
package fight_pkg;

  localparam int STATE_W = 4;

  localparam logic [STATE_W-1:0] S_HITSTUN   = 4'd9;
  localparam logic [STATE_W-1:0] S_BLOCKSTUN = 4'd10;

  typedef enum logic [0:0] {
    RS_ACTIVE = 1'b0,
    RS_OVER   = 1'b1
  } round_state_e;

  // True on the first cycle a player enters the given state.
  function automatic logic is_entry(input logic [STATE_W-1:0] cur,
                                    input logic [STATE_W-1:0] prev,
                                    input logic [STATE_W-1:0] target);
    return (cur == target) && (prev != target);
  endfunction

endpackage

// File: rtl/vitality_channel.sv
// One player's health/guard channel: stun edge detect, saturating counters,
// hit/guard-break pulses, sticky KO and (VITALITY_BLOCK_REGEN_EN) guard regen.
module vitality_channel
  import fight_pkg::*;
#(
  parameter int HEALTH_MAX   = 3,
  parameter int BLOCK_MAX    = 3,
  parameter int HEALTH_W     = 3,
  parameter int BLOCK_W      = 3,
  parameter int REGEN_FRAMES = 60
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               round_reset_i,
  input  logic               frame_tick_i,
  input  logic               freeze_i,
  input  logic [STATE_W-1:0] state_i,
  output logic [HEALTH_W-1:0] health_o,
  output logic [BLOCK_W-1:0]  block_o,
  output logic               hit_pulse_o,
  output logic               guard_break_o,
  output logic               ko_o,
  output logic               ko_next_o
);

  localparam logic [HEALTH_W-1:0] HEALTH_MAX_C = HEALTH_W'(HEALTH_MAX);
  localparam logic [BLOCK_W-1:0]  BLOCK_MAX_C  = BLOCK_W'(BLOCK_MAX);

  logic [STATE_W-1:0]  prev_q;
  logic [HEALTH_W-1:0] health_q, health_d;
  logic [BLOCK_W-1:0]  block_q, block_d;
  logic                hit_q, hit_d;
  logic                gb_q, gb_d;
  logic                ko_q, ko_d;
  logic                hit_edge_s, blk_edge_s;

`ifdef VITALITY_BLOCK_REGEN_EN
  localparam int RC_W = $clog2(REGEN_FRAMES) + 1;
  localparam logic [RC_W-1:0] REGEN_LAST_C = RC_W'(REGEN_FRAMES - 1);
  logic [RC_W-1:0] regen_q, regen_d;
`else
  logic unused_s;
  assign unused_s = frame_tick_i & (REGEN_FRAMES > 0);
`endif

  assign hit_edge_s = is_entry(state_i, prev_q, S_HITSTUN);
  assign blk_edge_s = is_entry(state_i, prev_q, S_BLOCKSTUN);

  // Next-state for health, guard, pulses, KO and regen counter.
  always_comb begin
    health_d = health_q;
    block_d  = block_q;
    hit_d    = 1'b0;
    gb_d     = 1'b0;
    ko_d     = ko_q;
`ifdef VITALITY_BLOCK_REGEN_EN
    regen_d  = regen_q;
`endif
    if (round_reset_i) begin
      health_d = HEALTH_MAX_C;
      block_d  = BLOCK_MAX_C;
      ko_d     = 1'b0;
`ifdef VITALITY_BLOCK_REGEN_EN
      regen_d  = '0;
`endif
    end else begin
      if (!freeze_i) begin
`ifdef VITALITY_BLOCK_REGEN_EN
        // Any blockstun or full guard parks the counter; a block edge implies blockstun.
        if (blk_edge_s || (state_i == S_BLOCKSTUN) || (block_q == BLOCK_MAX_C)) begin
          regen_d = '0;
        end else if (frame_tick_i) begin
          if (regen_q == REGEN_LAST_C) begin
            block_d = block_q + BLOCK_W'(1);
            regen_d = '0;
          end else begin
            regen_d = regen_q + RC_W'(1);
          end
        end else begin
          regen_d = regen_q;
        end
`endif
        if (hit_edge_s) begin
          if (health_q != '0) begin
            health_d = health_q - HEALTH_W'(1);
            hit_d    = 1'b1;
          end else begin
            health_d = health_q;
          end
        end else if (blk_edge_s) begin
          if (block_q != '0) begin
            block_d = block_q - BLOCK_W'(1);
          end else begin
            gb_d = 1'b1;
            if (health_q != '0) begin
              health_d = health_q - HEALTH_W'(1);
              hit_d    = 1'b1;
            end else begin
              health_d = health_q;
            end
          end
        end else begin
          health_d = health_q;
        end
      end else begin
        health_d = health_q;
      end
      if (health_d == '0) begin
        ko_d = 1'b1;
      end else begin
        ko_d = ko_q;
      end
    end
  end

  // Channel state registers; prev_q keeps sampling even during round_reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q   <= '0;
      health_q <= HEALTH_MAX_C;
      block_q  <= BLOCK_MAX_C;
      hit_q    <= 1'b0;
      gb_q     <= 1'b0;
      ko_q     <= 1'b0;
`ifdef VITALITY_BLOCK_REGEN_EN
      regen_q  <= '0;
`endif
    end else begin
      prev_q   <= state_i;
      health_q <= health_d;
      block_q  <= block_d;
      hit_q    <= hit_d;
      gb_q     <= gb_d;
      ko_q     <= ko_d;
`ifdef VITALITY_BLOCK_REGEN_EN
      regen_q  <= regen_d;
`endif
    end
  end

  assign health_o      = health_q;
  assign block_o       = block_q;
  assign hit_pulse_o   = hit_q;
  assign guard_break_o = gb_q;
  assign ko_o          = ko_q;
  assign ko_next_o     = ko_d;

endmodule

// File: rtl/vitality_tracker.sv
// N-player health/guard tracker with round-over/winner FSM.
// Optional guard regeneration is enabled by defining VITALITY_BLOCK_REGEN_EN.
module vitality_tracker
  import fight_pkg::*;
#(
  parameter int NUM_PLAYERS  = 2,
  parameter int HEALTH_MAX   = 3,
  parameter int BLOCK_MAX    = 3,
  parameter int HEALTH_W     = 3,
  parameter int BLOCK_W      = 3,
  parameter int REGEN_FRAMES = 60,
  parameter int ID_W         = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          round_reset_i,
  input  logic                          frame_tick_i,
  input  logic [NUM_PLAYERS*STATE_W-1:0] player_state_i,
  output logic [NUM_PLAYERS*HEALTH_W-1:0] health_o,
  output logic [NUM_PLAYERS*BLOCK_W-1:0]  block_o,
  output logic [NUM_PLAYERS-1:0]        hit_pulse_o,
  output logic [NUM_PLAYERS-1:0]        guard_break_o,
  output logic [NUM_PLAYERS-1:0]        ko_o,
  output logic                          round_over_o,
  output logic                          winner_valid_o,
  output logic [ID_W-1:0]               winner_id_o,
  output logic                          draw_o
);

  localparam int CNT_W = $clog2(NUM_PLAYERS + 1);

  round_state_e          state_q, state_d;
  logic                  win_valid_q, win_valid_d;
  logic [ID_W-1:0]       win_id_q, win_id_d;
  logic                  draw_q, draw_d;
  logic                  freeze_s;
  logic [NUM_PLAYERS-1:0] ko_next_s;
  logic [CNT_W-1:0]      alive_cnt_s, alive_next_cnt_s;
  logic [ID_W-1:0]       alive_next_id_s;

  assign freeze_s = (state_q == RS_OVER);

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_ch
    vitality_channel #(
      .HEALTH_MAX  (HEALTH_MAX),
      .BLOCK_MAX   (BLOCK_MAX),
      .HEALTH_W    (HEALTH_W),
      .BLOCK_W     (BLOCK_W),
      .REGEN_FRAMES(REGEN_FRAMES)
    ) u_ch (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .round_reset_i(round_reset_i),
      .frame_tick_i (frame_tick_i),
      .freeze_i     (freeze_s),
      .state_i      (player_state_i[STATE_W*g +: STATE_W]),
      .health_o     (health_o[HEALTH_W*g +: HEALTH_W]),
      .block_o      (block_o[BLOCK_W*g +: BLOCK_W]),
      .hit_pulse_o  (hit_pulse_o[g]),
      .guard_break_o(guard_break_o[g]),
      .ko_o         (ko_o[g]),
      .ko_next_o    (ko_next_s[g])
    );
  end

  // Survivor counts: registered KOs drive the FSM, next-cycle KOs drive the winner encoding.
  always_comb begin
    alive_cnt_s      = '0;
    alive_next_cnt_s = '0;
    alive_next_id_s  = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (!ko_o[i]) begin
        alive_cnt_s = alive_cnt_s + CNT_W'(1);
      end else begin
        alive_cnt_s = alive_cnt_s;
      end
      if (!ko_next_s[i]) begin
        alive_next_cnt_s = alive_next_cnt_s + CNT_W'(1);
        alive_next_id_s  = ID_W'(i);
      end else begin
        alive_next_cnt_s = alive_next_cnt_s;
      end
    end
  end

  // Round FSM next state and winner/draw outputs for the coming cycle.
  always_comb begin
    state_d     = state_q;
    win_valid_d = 1'b0;
    win_id_d    = '0;
    draw_d      = 1'b0;
    if (round_reset_i) begin
      state_d = RS_ACTIVE;
    end else begin
      case (state_q)
        RS_ACTIVE: begin
          if (alive_cnt_s <= CNT_W'(1)) begin
            state_d = RS_OVER;
          end else begin
            state_d = RS_ACTIVE;
          end
        end
        RS_OVER: state_d = RS_OVER;
        default: state_d = RS_ACTIVE;
      endcase
    end
    if (state_d == RS_OVER) begin
      if (alive_next_cnt_s == CNT_W'(1)) begin
        win_valid_d = 1'b1;
        win_id_d    = alive_next_id_s;
      end else if (alive_next_cnt_s == CNT_W'(0)) begin
        draw_d = 1'b1;
      end else begin
        win_valid_d = 1'b0;
      end
    end else begin
      win_valid_d = 1'b0;
    end
  end

  // Round FSM and result registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= RS_ACTIVE;
      win_valid_q <= 1'b0;
      win_id_q    <= '0;
      draw_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_valid_q <= win_valid_d;
      win_id_q    <= win_id_d;
      draw_q      <= draw_d;
    end
  end

  assign round_over_o   = (state_q == RS_OVER);
  assign winner_valid_o = win_valid_q;
  assign winner_id_o    = win_id_q;
  assign draw_o         = draw_q;

endmodule

// File: tb/tb_vitality_tracker.sv
// Self-checking bench for vitality_tracker: behavioural model plus directed
// and random stimulus; regen scenarios run when VITALITY_BLOCK_REGEN_EN is set.
module tb_vitality_tracker;

  localparam int N = 2, HMAX = 3, BMAX = 3, HW = 3, BW = 3, IDW = 1;
`ifdef VITALITY_BLOCK_REGEN_EN
  localparam int RF = 4;
`else
  localparam int RF = 60;
`endif

  logic            clk = 1'b0, rst = 1'b1, round_reset = 1'b0, frame_tick = 1'b0;
  logic [N*4-1:0]  player_state = '0;
  logic [N*HW-1:0] health;
  logic [N*BW-1:0] block;
  logic [N-1:0]    hit_pulse, guard_break, ko;
  logic            round_over, winner_valid, draw;
  logic [IDW-1:0]  winner_id;

  vitality_tracker #(
    .NUM_PLAYERS(N), .HEALTH_MAX(HMAX), .BLOCK_MAX(BMAX), .HEALTH_W(HW),
    .BLOCK_W(BW), .REGEN_FRAMES(RF), .ID_W(IDW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .round_reset_i(round_reset), .frame_tick_i(frame_tick),
    .player_state_i(player_state), .health_o(health), .block_o(block),
    .hit_pulse_o(hit_pulse), .guard_break_o(guard_break), .ko_o(ko),
    .round_over_o(round_over), .winner_valid_o(winner_valid),
    .winner_id_o(winner_id), .draw_o(draw)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: plain integers per player, one round-over flag.
  int m_h[N], m_b[N], m_prev[N], m_cnt[N];
  bit m_ko[N], m_hp[N], m_gb[N];
  bit m_over;
  int m_alive, m_ps;
  bit m_hit, m_blk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_h[i] = HMAX; m_b[i] = BMAX; m_prev[i] = 0; m_cnt[i] = 0;
        m_ko[i] = 0; m_hp[i] = 0; m_gb[i] = 0;
      end
      m_over = 0;
    end else begin
      m_alive = 0;
      for (int i = 0; i < N; i++) if (!m_ko[i]) m_alive++;
      for (int i = 0; i < N; i++) begin
        m_ps = int'(player_state[4*i +: 4]);
        m_hp[i] = 0; m_gb[i] = 0;
        if (round_reset) begin
          m_h[i] = HMAX; m_b[i] = BMAX; m_ko[i] = 0; m_cnt[i] = 0;
        end else if (!m_over) begin
          m_hit = (m_ps == 9) && (m_prev[i] != 9);
          m_blk = (m_ps == 10) && (m_prev[i] != 10);
`ifdef VITALITY_BLOCK_REGEN_EN
          if (m_blk || m_ps == 10 || m_b[i] == BMAX) m_cnt[i] = 0;
          else if (frame_tick) begin
            if (m_cnt[i] == RF - 1) begin m_b[i]++; m_cnt[i] = 0; end
            else m_cnt[i]++;
          end
`endif
          if (m_hit) begin
            if (m_h[i] > 0) begin m_h[i]--; m_hp[i] = 1; end
          end else if (m_blk) begin
            if (m_b[i] > 0) m_b[i]--;
            else begin
              m_gb[i] = 1;
              if (m_h[i] > 0) begin m_h[i]--; m_hp[i] = 1; end
            end
          end
          if (m_h[i] == 0) m_ko[i] = 1;
        end
        m_prev[i] = m_ps;
      end
      if (round_reset) m_over = 0;
      else if (m_alive <= 1) m_over = 1;
    end
  end

  // Compare process: every settled cycle, all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      int alive, last;
      alive = 0; last = 0;
      for (int i = 0; i < N; i++) begin
        check($sformatf("health%0d", i), 32'(health[HW*i +: HW]), 32'(m_h[i]));
        check($sformatf("block%0d", i), 32'(block[BW*i +: BW]), 32'(m_b[i]));
        check($sformatf("hit_pulse%0d", i), 32'(hit_pulse[i]), 32'(m_hp[i]));
        check($sformatf("guard_break%0d", i), 32'(guard_break[i]), 32'(m_gb[i]));
        check($sformatf("ko%0d", i), 32'(ko[i]), 32'(m_ko[i]));
        if (!m_ko[i]) begin alive++; last = i; end
      end
      check("round_over", 32'(round_over), 32'(m_over));
      check("winner_valid", 32'(winner_valid), 32'(m_over && alive == 1));
      check("winner_id", 32'(winner_id), (m_over && alive == 1) ? 32'(last) : 32'd0);
      check("draw", 32'(draw), 32'(m_over && alive == 0));
    end
  end

  task automatic step(input logic [3:0] s0, input logic [3:0] s1, input logic rr, input logic tk);
    player_state = {s1, s0};
    round_reset  = rr;
    frame_tick   = tk;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset_health", 32'(health), 32'd27);
    check("reset_block", 32'(block), 32'd27);
    check("reset_round_over", 32'(round_over), 32'd0);

    // Single hit, then a held hitstun must not re-count.
    step(4'd9, 4'd0, 1'b0, 1'b0);
    check("hit_health0", 32'(health[2:0]), 32'd2);
    check("hit_pulse_first", 32'(hit_pulse), 32'd1);
    repeat (10) step(4'd9, 4'd0, 1'b0, 1'b0);
    check("held_health0", 32'(health[2:0]), 32'd2);
    check("held_pulse", 32'(hit_pulse), 32'd0);
    step(4'd0, 4'd0, 1'b0, 1'b0);

    // Four guards on player1: 2,1,0 then guard break.
    for (int k = 0; k < 4; k++) begin
      step(4'd0, 4'd10, 1'b0, 1'b0);
      check("block1_seq", 32'(block[5:3]), (k < 3) ? 32'(2 - k) : 32'd0);
      step(4'd0, 4'd0, 1'b0, 1'b0);
    end
    check("gb_health1", 32'(health[5:3]), 32'd2);

    // Player0 KO, winner player1, later hit ignored.
    step(4'd9, 4'd0, 1'b0, 1'b0);
    step(4'd0, 4'd0, 1'b0, 1'b0);
    step(4'd9, 4'd0, 1'b0, 1'b0);
    check("ko_vec", 32'(ko), 32'd1);
    check("ko_round_not_over_yet", 32'(round_over), 32'd0);
    step(4'd0, 4'd0, 1'b0, 1'b0);
    check("win_round_over", 32'(round_over), 32'd1);
    check("win_valid", 32'(winner_valid), 32'd1);
    check("win_id", 32'(winner_id), 32'd1);
    step(4'd0, 4'd9, 1'b0, 1'b0);
    check("frozen_health1", 32'(health[5:3]), 32'd2);

    // Simultaneous final KOs give a draw.
    step(4'd0, 4'd0, 1'b1, 1'b0);
    check("rr_health", 32'(health), 32'd27);
    check("rr_round_over", 32'(round_over), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step(4'd9, 4'd9, 1'b0, 1'b0);
      step(4'd0, 4'd0, 1'b0, 1'b0);
    end
    check("draw_ko", 32'(ko), 32'd3);
    check("draw_flag", 32'(draw), 32'd1);
    check("draw_no_winner", 32'(winner_valid), 32'd0);

    // round_reset during a held hitstun drops that edge.
    step(4'd9, 4'd0, 1'b1, 1'b0);
    check("rrhold_health", 32'(health), 32'd27);
    repeat (3) step(4'd9, 4'd0, 1'b0, 1'b0);
    check("rrhold_no_hit", 32'(health[2:0]), 32'd3);
    step(4'd0, 4'd0, 1'b0, 1'b0);
    step(4'd9, 4'd0, 1'b0, 1'b0);
    check("rrhold_reentry", 32'(health[2:0]), 32'd2);

`ifdef VITALITY_BLOCK_REGEN_EN
    step(4'd0, 4'd0, 1'b1, 1'b0);
    repeat (2) begin step(4'd10, 4'd0, 1'b0, 1'b0); step(4'd0, 4'd0, 1'b0, 1'b0); end
    check("regen_start", 32'(block[2:0]), 32'd1);
    repeat (4) step(4'd0, 4'd0, 1'b0, 1'b1);
    check("regen_plus1", 32'(block[2:0]), 32'd2);
    repeat (8) step(4'd0, 4'd0, 1'b0, 1'b1);
    check("regen_hold", 32'(block[2:0]), 32'd3);
    repeat (2) begin step(4'd10, 4'd0, 1'b0, 1'b0); step(4'd0, 4'd0, 1'b0, 1'b0); end
    repeat (3) step(4'd0, 4'd0, 1'b0, 1'b1);
    step(4'd10, 4'd0, 1'b0, 1'b1);
    check("regen_edge_wins", 32'(block[2:0]), 32'd0);
    step(4'd0, 4'd0, 1'b0, 1'b0);
    repeat (3) step(4'd0, 4'd0, 1'b0, 1'b1);
    check("regen_restart", 32'(block[2:0]), 32'd0);
    step(4'd0, 4'd0, 1'b0, 1'b1);
    check("regen_after_clear", 32'(block[2:0]), 32'd1);
`endif

    // Randomised phase with one mid-run async reset during a stun.
    for (int c = 0; c < 800; c++) begin
      logic [3:0] s[2];
      for (int i = 0; i < 2; i++) begin
        case ($urandom_range(0, 3))
          0: s[i] = 4'd0;
          1: s[i] = 4'd9;
          2: s[i] = 4'd10;
          default: s[i] = 4'($urandom_range(0, 15));
        endcase
      end
      if (c == 400) begin
        chk_en = 1'b0;
        player_state = {4'd0, 4'd9};
        round_reset = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        step(4'd9, 4'd0, 1'b0, 1'b0);
        check("post_rst_stun_edge", 32'(health[2:0]), 32'd2);
      end
      step(s[0], s[1], ($urandom_range(0, 39) == 0), $urandom_range(0, 1) == 1);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
